// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised multi-port register file.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } rf_state_e;

    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_ADDR_W   = 5;
    localparam int unsigned RF_NRD_MAX  = 4;
    localparam int unsigned RF_ADDR_MAX = 16;
    localparam int unsigned RF_RBUS_W   = RF_NRD_MAX * RF_ADDR_MAX;

    // Extract the aw-bit read address of port idx from a zero-extended packed bus.
    function automatic logic [RF_ADDR_MAX-1:0] port_addr(
        input logic [RF_RBUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          aw
    );
        logic [RF_RBUS_W-1:0]   shifted;
        logic [RF_ADDR_MAX-1:0] mask;
        shifted = bus >> (idx * aw);
        mask    = RF_ADDR_MAX'((32'd1 << aw) - 32'd1);
        return shifted[RF_ADDR_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: enable, hardwired-zero register, optional write bypass.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idle,
    input  logic              clear_req,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (idle && ren) begin
            if (clear_req) begin
                rdata_d = '0;
            end else if ((ZERO_REG != 0) && (raddr == '0)) begin
                rdata_d = '0;
            end else if ((BYPASS != 0) && wr_valid && (waddr == raddr)) begin
                // wr_valid already excludes register-0 drops, so those never forward
                rdata_d = wdata;
            end else begin
                rdata_d = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with zero register, bypass and a hardware clear sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic [NRD-1:0]        ren,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    rf_state_e         state_d, state_q;
    logic [ADDR_W-1:0] ptr_d, ptr_q;
    logic              busy_d, busy_q;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              idle;
    logic              wr_valid;
    logic [RF_RBUS_W-1:0] raddr_ext;

    assign idle      = (state_q == ST_IDLE);
    assign wr_valid  = idle && !clear_req && we && !((ZERO_REG != 0) && (waddr == '0));
    assign raddr_ext = RF_RBUS_W'(raddr);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // The sweep and functional writes share the single array write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
        end else if (wr_valid) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [ADDR_W-1:0] port_raddr;
        logic [DATA_W-1:0] port_mem;

        assign port_raddr = ADDR_W'(port_addr(raddr_ext, gi, ADDR_W));
        assign port_mem   = mem_q[port_raddr];

        regfile_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .clk       (clk),
            .rst_n     (rst_n),
            .idle      (idle),
            .clear_req (clear_req),
            .ren       (ren[gi]),
            .raddr     (port_raddr),
            .mem_rdata (port_mem),
            .wr_valid  (wr_valid),
            .waddr     (waddr),
            .wdata     (wdata),
            .rdata     (rdata[gi*DATA_W +: DATA_W])
        );
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp, run with BYPASS=1 and BYPASS=0 side by side.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear_req = 1'b0;
    logic [1:0]  ren = '0;
    logic [9:0]  raddr = '0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        busy_b, busy_n;
    logic [63:0] rdata_b, rdata_n;

    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_b),
        .ren(ren), .raddr(raddr), .rdata(rdata_b),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_n),
        .ren(ren), .raddr(raddr), .rdata(rdata_n),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is just a countdown of blocked edges; memory is zero once it ends.
    int unsigned m_left = 32;
    logic [31:0] m_mem [32];
    logic [31:0] m_rd [2][2];   // [bypass][port]

    initial begin
        foreach (m_mem[a]) m_mem[a] = '0;
        foreach (m_rd[b, p]) m_rd[b][p] = '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 32;
            foreach (m_rd[b, p]) m_rd[b][p] = '0;
            foreach (m_mem[a]) m_mem[a] = '0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (clear_req) begin
            m_left = 32;
            for (int p = 0; p < 2; p++)
                if (ren[p]) begin
                    m_rd[0][p] = '0;
                    m_rd[1][p] = '0;
                end
            foreach (m_mem[a]) m_mem[a] = '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                int unsigned a;
                a = raddr[p*5 +: 5];
                if (ren[p]) begin
                    if (a == 0) begin
                        m_rd[0][p] = '0;
                        m_rd[1][p] = '0;
                    end else begin
                        m_rd[0][p] = m_mem[a];
                        m_rd[1][p] = (we && waddr == a) ? wdata : m_mem[a];
                    end
                end
            end
            if (we && waddr != 0) m_mem[waddr] = wdata;
        end
    end

    always @(negedge clk) begin
        chk("busy_byp", {63'd0, busy_b}, {63'd0, m_left > 0});
        chk("busy_nb",  {63'd0, busy_n}, {63'd0, m_left > 0});
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rd_byp_p%0d", p), {32'd0, rdata_b[p*32 +: 32]}, {32'd0, m_rd[1][p]});
            chk($sformatf("rd_nb_p%0d", p),  {32'd0, rdata_n[p*32 +: 32]}, {32'd0, m_rd[0][p]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d; ren = '0;
        tick();
        we = 1'b0;
    endtask

    task automatic count_busy(input string name, input int unsigned exp);
        int unsigned n;
        n = 0;
        while (busy_b && n < 100) begin
            if (n == 5) clear_req = 1'b1;
            tick();
            clear_req = 1'b0;
            n++;
        end
        chk(name, 64'(n), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset sweep with a write held throughout
        we = 1'b1; waddr = 5'd3; wdata = 32'd5;
        #1 rst_n = 1'b0;
        #1 chk("rst_rdata_byp", rdata_b, 64'd0);
        chk("rst_rdata_nb", rdata_n, 64'd0);
        chk("rst_busy", {63'd0, busy_b}, 64'd1);
        #20 rst_n = 1'b1;
        begin
            int unsigned n;
            n = 0;
            do begin
                tick();
                n++;
            end while (busy_b && n < 100);
            chk("reset_sweep_len", 64'(n), 64'd32);
        end
        we = 1'b0;
        ren = 2'b01; raddr = {5'd0, 5'd3};
        tick();
        chk("addr3_after_sweep", {32'd0, rdata_b[31:0]}, 64'd0);

        // Basic write/read
        wr(5'd2, 32'h0000_0009);
        wr(5'd4, 32'hDEAD_BEEF);
        ren = 2'b11; raddr = {5'd4, 5'd2};
        tick();
        chk("basic_p0", {32'd0, rdata_b[31:0]}, 64'h9);
        chk("basic_p1", {32'd0, rdata_b[63:32]}, 64'hDEAD_BEEF);

        // Zero register, separate edges and same edge
        wr(5'd0, 32'h1234);
        ren = 2'b01; raddr = '0;
        tick();
        chk("zero_read", {32'd0, rdata_b[31:0]}, 64'd0);
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234; ren = 2'b01; raddr = '0;
        tick();
        we = 1'b0;
        chk("zero_bypass", {32'd0, rdata_b[31:0]}, 64'd0);
        chk("zero_nb", {32'd0, rdata_n[31:0]}, 64'd0);

        // Same-edge bypass versus read-before-write
        wr(5'd7, 32'd1);
        we = 1'b1; waddr = 5'd7; wdata = 32'd6; ren = 2'b01; raddr = {5'd0, 5'd7};
        tick();
        we = 1'b0;
        chk("bypass_new", {32'd0, rdata_b[31:0]}, 64'd6);
        chk("nobypass_old", {32'd0, rdata_n[31:0]}, 64'd1);
        tick();
        chk("nobypass_next", {32'd0, rdata_n[31:0]}, 64'd6);

        // Read-enable hold
        wr(5'd10, 32'd9);
        ren = 2'b10; raddr = {5'd10, 5'd0};
        tick();
        chk("hold_load", {32'd0, rdata_b[63:32]}, 64'd9);
        ren = 2'b00; raddr = {5'd11, 5'd0};
        tick();
        tick();
        chk("hold_keep", {32'd0, rdata_b[63:32]}, 64'd9);

        // clear_req colliding with a write; a second request mid-sweep must not extend it
        clear_req = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hAA; ren = 2'b11;
        tick();
        clear_req = 1'b0; we = 1'b0;
        chk("clear_busy", {63'd0, busy_b}, 64'd1);
        count_busy("clear_sweep_len", 32);
        ren = 2'b01; raddr = {5'd0, 5'd5};
        tick();
        chk("clear_drop_write", {32'd0, rdata_b[31:0]}, 64'd0);

        // Async reset zeroes rdata immediately, and restarts a sweep in progress
        wr(5'd8, 32'h77);
        ren = 2'b01; raddr = {5'd0, 5'd8};
        tick();
        chk("pre_reset_load", {32'd0, rdata_b[31:0]}, 64'h77);
        rst_n = 1'b0;
        #1 chk("async_rst_rdata", rdata_b, 64'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        begin
            int unsigned n;
            n = 0;
            while (busy_b && n < 100) begin
                tick();
                n++;
            end
            chk("restart_sweep_len", 64'(n), 64'd32);
        end

        // Randomised traffic over a narrow address range to provoke collisions
        for (int i = 0; i < 800; i++) begin
            we        = ($urandom_range(0, 99) < 60);
            waddr     = 5'($urandom_range(0, 7));
            wdata     = $urandom;
            ren       = 2'($urandom_range(0, 3));
            raddr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            clear_req = ($urandom_range(0, 149) == 0);
            if (clear_req) ren = 2'b11;
            tick();
        end
        clear_req = 1'b0; we = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
